rr_grant_payload_queue: RTL
===========================

// Module: rr_grant_payload_queue
//
// PURPOSE
// Downstream stage of round_robin_arbiter. Consumes the one-hot gnt vector,
// selects the granted agent's payload, and queues {id, data} in a small
// FIFO that drains to a single ready/valid sink. It pulses ack back to the
// winning agent only when the payload is actually captured. A grant that
// arrives while the queue is full is dropped; the agent keeps req high and
// the arbiter re-grants it on a later rotation.
//
// PARAMETERS
// N      8  number of agents; must match the arbiter's N
// W      8  payload width per agent, in bits
// DEPTH  2  queue entries; a power of two, >= 2
// (localparam IDW = $clog2(N), the agent-id width)
//
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous active-low reset
// gnt        in   N      one-hot grant from round_robin_arbiter
// in_data    in   N*W    agent i's payload at bits [i*W +: W]
// ack        out  N      combinational; ack[i]=1 means agent i's payload is captured this cycle
// out_valid  out  1      queue head is valid
// out_ready  in   1      sink accepts the head
// out_id     out  IDW    agent index of the head entry
// out_data   out  W      payload of the head entry
// drop_cnt   out  16     number of grants refused because the queue was full; saturates at 0xFFFF
// gnt_err    out  1      sticky; set when gnt is multi-hot
//
// BEHAVIOUR
// - Reset, asynchronous: queue flushed, with count=0 and read/write pointers at 0.
//   Outputs: out_valid=0, out_id=0, out_data=0, drop_cnt=0, gnt_err=0.
//   ack is forced to 0 while rst_n=0.
// - pop   = out_valid & out_ready.
// - space = (count < DEPTH) | pop. A full queue accepts a push in the same cycle as a pop.
// - onehot = (gnt != 0) & ((gnt & (gnt-1)) == 0).
// - accept = onehot & space & rst_n.
// - ack = accept ? gnt : 0, in the same cycle as the grant.
//   The agent advances req and in_data at the next clk edge.
// - There is a combinational path out_ready -> ack. This path is permitted and must be documented in synthesis constraints.
// - Push on accept: the entry stores {encode(gnt), in_data[id*W +: W]}.
// - The entry is visible on out_* on the cycle after the push. Push-to-valid latency is 1 clk.
// - Head-of-line behaviour: out_id and out_data hold stable while out_valid=1 and out_ready=0.
// - count: +1 on push only, -1 on pop only, unchanged on push and pop together.
//   count never exceeds DEPTH and never goes negative.
// - Pointers are IDW-independent, $clog2(DEPTH) bits wide, and wrap modulo DEPTH.
// - When the queue is empty, out_data and out_id hold their last values. out_valid=0 qualifies them.
// - Dropped grant (onehot & ~space): no ack, no push. drop_cnt increments and saturates.
// - Multi-hot gnt: no ack, no push, and gnt_err is set to 1 until reset. drop_cnt is unchanged.
// - gnt=0: idle, with no ack and no state change except pops.
// - Ordering: entries leave in the order they were accepted. No entry is duplicated or lost.
// - Reset mid-operation discards all queued entries immediately.
//
// TESTING
// 1. out_ready=1; gnt=8'b00000100 for 1 cycle; in_data[2]=8'hA5.
//    -> ack=8'b00000100 in that cycle.
//    -> Next cycle: out_valid=1, out_id=2, out_data=8'hA5.
//    -> The cycle after that: out_valid=0.
// 2. out_ready=0; grants on successive cycles to agent 0 (data 8'h10), agent 1 (8'h11), agent 2 (8'h12).
//    -> The first two are acked. Agent 2 gets no ack, and drop_cnt=1.
//    -> Then out_ready=1: the sink receives (0,8'h10) then (1,8'h11).
// 3. Queue full; out_ready=1; gnt=8'b10000000 with data 8'h77.
//    -> ack[7]=1, pop and push occur together, and count stays 2.
//    -> 8'h77 emerges after the older entry.
// 4. gnt=8'b00000011.
//    -> ack=0, no push, gnt_err=1.
//    -> gnt_err stays 1 through later valid grants until rst_n is pulsed.
// 5. Two entries queued; rst_n=0 asserted mid-cycle.
//    -> out_valid=0 and drop_cnt=0 immediately, with no clock edge.
//    -> After release, the first grant behaves as in scenario 1.
// 6. Chain with round_robin_arbiter (N=8), req=8'hFF, sink ready 1 cycle in 2.
//    -> Every ack matches the arbiter gnt.
//    -> The out_id sequence equals the accepted-grant sequence, with no loss or duplication.
//    -> drop_cnt equals the number of grants refused while the queue was full.

Source files
------------

// File: rtl/rr_grant_payload_queue_if.sv
// Grant/payload/sink bundle between the arbiter side, the payload queue and its sink.
//   gnt       one-hot grant from the arbiter
//   in_data   packed agent payloads, agent i at [i*W +: W]
//   ack       capture acknowledge back to the granted agent (combinational)
//   out_valid queue head valid
//   out_ready sink accepts the head
//   out_id    agent index of the head entry
//   out_data  payload of the head entry
interface rr_grant_payload_queue_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 8
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   gnt;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   ack;
    logic           out_valid;
    logic           out_ready;
    logic [IDW-1:0] out_id;
    logic [W-1:0]   out_data;

    // Upstream arbiter/agents plus the sink.
    modport master (
        output gnt, in_data, out_ready,
        input  ack, out_valid, out_id, out_data
    );

    // The payload queue.
    modport slave (
        input  gnt, in_data, out_ready,
        output ack, out_valid, out_id, out_data
    );
endinterface

// File: rtl/rr_grant_payload_queue.sv
// Captures the granted agent's payload into a small FIFO and drains it to a
// single ready/valid sink; acks the agent only when the payload is captured.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         grant/payload/sink bundle (slave side)
//   drop_cnt    saturating count of grants refused because the queue was full
//   gnt_err     sticky flag, set on a multi-hot grant
//
// Timing note: out_ready -> ack is a combinational path (a full queue can
// accept a push in the cycle it pops); it must be covered in the synthesis
// constraints together with gnt -> ack.
module rr_grant_payload_queue #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rr_grant_payload_queue_if.slave   bus,
    output logic [15:0]               drop_cnt,
    output logic                      gnt_err
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]  count, count_nxt;
    entry_t         head_q, head_nxt, push_entry;
    logic           valid_q;
    logic [15:0]    drop_nxt;
    logic           err_nxt;

    logic onehot, multihot, pop, space, accept, drop;

    // Grant qualification and the capture decision.
    always_comb begin
        onehot   = (bus.gnt != '0) && ((bus.gnt & (bus.gnt - N'(1))) == '0);
        multihot = (bus.gnt != '0) && !onehot;
        pop      = valid_q & bus.out_ready;
        space    = (count < CW'(DEPTH)) | pop;
        accept   = onehot & space & rst_n;
        drop     = onehot & ~space;
        bus.ack  = accept ? bus.gnt : '0;
    end

    // Encode the grant and select that agent's payload.
    always_comb begin
        push_entry = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.gnt[i]) begin
                push_entry.id   = IDW'(i);
                push_entry.data = bus.in_data[i*W +: W];
            end
        end
    end

    // Next queue state; the head register is preloaded with whatever entry
    // sits at the read pointer after this cycle, bypassing a same-cycle push.
    always_comb begin
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        head_nxt   = head_q;
        drop_nxt   = drop_cnt;
        err_nxt    = gnt_err | multihot;

        if (accept && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !accept) begin
            count_nxt = count - CW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
        end
        if (count_nxt != '0) begin
            if (accept && (wr_ptr == rd_ptr_nxt)) begin
                head_nxt = push_entry;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
        if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_nxt = drop_cnt + 16'd1;
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            drop_cnt <= '0;
            gnt_err  <= 1'b0;
        end else begin
            count    <= count_nxt;
            rd_ptr   <= rd_ptr_nxt;
            head_q   <= head_nxt;
            valid_q  <= (count_nxt != '0);
            drop_cnt <= drop_nxt;
            gnt_err  <= err_nxt;
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Storage array; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_id    = head_q.id;
    assign bus.out_data  = head_q.data;
endmodule
